// File: rtl/vpm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vpm_pkg
// Description : Shared types and constants for the variable-precision
//               multiplier sequencer. It provides the precision codes, the
//               sequencer state enum, the operand, limb and result widths,
//               and helpers that turn a precision code into a limb count and
//               an operand mask.
// Revision    : 1.0 - initial release
// ============================================================================
package vpm_pkg;

    localparam int OP_W   = 64;
    localparam int LIMB_W = 16;
    localparam int RES_W  = 128;

    localparam logic [1:0] PREC_16 = 2'd0;
    localparam logic [1:0] PREC_32 = 2'd1;
    localparam logic [1:0] PREC_48 = 2'd2;
    localparam logic [1:0] PREC_64 = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        MUL  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Number of 16-bit limbs per operand for a precision code (1..4).
    function automatic logic [2:0] limbs(input logic [1:0] p);
        return {1'b0, p} + 3'd1;
    endfunction

    // Keeps the low 16*(p+1) bits of an operand.
    function automatic logic [OP_W-1:0] prec_mask(input logic [1:0] p);
        logic [OP_W-1:0] m;
        case (p)
            PREC_16: m = 64'h0000_0000_0000_FFFF;
            PREC_32: m = 64'h0000_0000_FFFF_FFFF;
            PREC_48: m = 64'h0000_FFFF_FFFF_FFFF;
            PREC_64: m = 64'hFFFF_FFFF_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vpm_pp16x16.sv
`default_nettype none
// ============================================================================
// Module      : vpm_pp16x16
// Description : Combinational 16x16 unsigned partial-product unit. It is the
//               single multiplier resource that the sequencer time-shares.
// Ports       : a, b  - 16-bit unsigned limbs
//               p     - 32-bit product a*b
// Revision    : 1.0 - initial release
// ============================================================================
module vpm_pp16x16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    assign p = {16'h0000, a} * {16'h0000, b};

endmodule
`default_nettype wire

// File: rtl/vpm_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vpm_mul_sequencer
// Description : Multi-cycle variable-precision multiplier controller. It
//               latches two operands with a precision code and a signed flag,
//               reduces them to masked magnitudes, and accumulates N*N limb
//               partial products from one shared 16x16 unit. It then applies
//               the sign and presents a 128-bit product.
// Ports       : clk, rst_n           - clock, async active-low reset
//               in_valid/in_ready    - request handshake (ready only in IDLE)
//               prec, signed_op, a, b- request payload
//               out_valid/out_ready  - result handshake
//               result               - 128-bit product, stable while valid
//               busy                 - high while PREP, MUL or FIX
// Revision    : 1.0 - initial release
// ============================================================================
module vpm_mul_sequencer #(
    parameter int OP_W   = 64,
    parameter int LIMB_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        prec,
    input  logic              signed_op,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*OP_W-1:0] result,
    output logic              busy
);

    import vpm_pkg::*;

    state_t               r_state;
    state_t               w_next;

    logic [OP_W-1:0]      r_mag_a;
    logic [OP_W-1:0]      r_mag_b;
    logic [1:0]           r_prec;
    logic                 r_signed;
    logic                 r_neg;
    logic [1:0]           r_i;
    logic [1:0]           r_j;
    logic [2*OP_W-1:0]    r_acc;
    logic [2*OP_W-1:0]    r_result;

    logic                 w_sign_a;
    logic                 w_sign_b;
    logic [OP_W-1:0]      w_negm_a;
    logic [OP_W-1:0]      w_negm_b;
    logic [LIMB_W-1:0]    w_limb_a;
    logic [LIMB_W-1:0]    w_limb_b;
    logic [2*LIMB_W-1:0]  w_pp;
    logic [2:0]           w_limb_sum;
    logic [6:0]           w_shamt;
    logic [2*OP_W-1:0]    w_pp_shifted;
    logic                 w_last_i;
    logic                 w_last_j;

    // Sign bit sits at 16*prec+15, which is exactly {prec, 4'hF}.
    assign w_sign_a = r_signed & r_mag_a[{r_prec, 4'hF}];
    assign w_sign_b = r_signed & r_mag_b[{r_prec, 4'hF}];

    // Negation stays inside the selected width; -2^(W-1) maps onto itself,
    // which is the correct unsigned magnitude 2^(W-1).
    assign w_negm_a = (~r_mag_a + 64'd1) & prec_mask(r_prec);
    assign w_negm_b = (~r_mag_b + 64'd1) & prec_mask(r_prec);

    assign w_limb_a = r_mag_a[{r_i, 4'h0} +: LIMB_W];
    assign w_limb_b = r_mag_b[{r_j, 4'h0} +: LIMB_W];

    vpm_pp16x16 u_pp (
        .a (w_limb_a),
        .b (w_limb_b),
        .p (w_pp)
    );

    assign w_limb_sum   = {1'b0, r_i} + {1'b0, r_j};
    assign w_shamt      = {w_limb_sum, 4'h0};
    assign w_pp_shifted = {{(2*OP_W-2*LIMB_W){1'b0}}, w_pp} << w_shamt;

    assign w_last_j = ({1'b0, r_j} == (limbs(r_prec) - 3'd1));
    assign w_last_i = ({1'b0, r_i} == (limbs(r_prec) - 3'd1));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and handshake outputs, all decoded from registered state
    // ------------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = PREP;
                end
            end
            PREP: begin
                busy   = 1'b1;
                w_next = MUL;
            end
            MUL: begin
                busy = 1'b1;
                if (w_last_i && w_last_j) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                busy   = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_prec   <= '0;
            r_signed <= 1'b0;
            r_neg    <= 1'b0;
            r_i      <= '0;
            r_j      <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mag_a  <= a & prec_mask(prec);
                        r_mag_b  <= b & prec_mask(prec);
                        r_prec   <= prec;
                        r_signed <= signed_op;
                    end
                end
                PREP: begin
                    r_mag_a <= w_sign_a ? w_negm_a : r_mag_a;
                    r_mag_b <= w_sign_b ? w_negm_b : r_mag_b;
                    r_neg   <= w_sign_a ^ w_sign_b;
                    r_acc   <= '0;
                    r_i     <= '0;
                    r_j     <= '0;
                end
                MUL: begin
                    // Magnitude product is below 2^(2W), so no carry is lost.
                    r_acc <= r_acc + w_pp_shifted;
                    if (w_last_j) begin
                        r_j <= '0;
                        r_i <= w_last_i ? 2'd0 : r_i + 2'd1;
                    end else begin
                        r_j <= r_j + 2'd1;
                    end
                end
                FIX: begin
                    // Full-width negate gives correct sign extension, and a
                    // zero accumulator stays zero.
                    r_result <= r_neg ? (~r_acc + 128'd1) : r_acc;
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_vpm_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vpm_mul_sequencer
// Description : Self-checking bench for vpm_mul_sequencer. A cycle-level
//               reference model gives the expected handshakes and products.
//               Directed requests carry hand-computed products and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vpm_mul_sequencer;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    prec = 2'd0;
    logic          signed_op = 1'b0;
    logic [63:0]   a = '0;
    logic [63:0]   b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [127:0]  result;
    logic          busy;

    int total = 0;
    int bad   = 0;

    vpm_mul_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prec      (prec),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference product: extend both operands to 128 bits from the selected
    // width, then take the product modulo 2^128.
    function automatic logic [127:0] model_prod(input logic [1:0] p, input logic s,
                                                input logic [63:0] x, input logic [63:0] y);
        int w;
        logic [127:0] ex;
        logic [127:0] ey;
        w  = 16 * (int'(p) + 1);
        ex = '0;
        ey = '0;
        for (int k = 0; k < 128; k++) begin
            if (k < w) begin
                ex[k] = x[k];
                ey[k] = y[k];
            end else if (s) begin
                ex[k] = x[w-1];
                ey[k] = y[w-1];
            end
        end
        return ex * ey;
    endfunction

    // Reference model: after acceptance it stays busy for N*N+2 cycles, then
    // holds the product until the consumer takes it.
    int           m_cnt  = 0;
    logic         m_ov   = 1'b0;
    logic [127:0] m_res  = '0;
    logic [127:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_ov  <= 1'b0;
            m_res <= '0;
        end else if (m_ov) begin
            if (out_ready) m_ov <= 1'b0;
        end else if (m_cnt != 0) begin
            if (m_cnt == 1) begin
                m_ov  <= 1'b1;
                m_res <= m_pend;
            end
            m_cnt <= m_cnt - 1;
        end else if (in_valid) begin
            m_cnt  <= (int'(prec) + 1) * (int'(prec) + 1) + 2;
            m_pend <= model_prod(prec, signed_op, a, b);
        end
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (!out_valid) check("timeout_out_valid", {127'd0, out_valid}, 128'd1);
    endtask

    task automatic do_op(input string nm, input logic [1:0] p, input logic s,
                         input logic [63:0] av, input logic [63:0] bv,
                         input logic [127:0] exp, input int lat);
        int cnt;
        @(negedge clk);
        prec = p; signed_op = s; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(cnt);
        if (lat > 0) check({nm, "_latency"}, 128'(cnt), 128'(lat));
        check({nm, "_result"}, result, exp);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int cnt;
        #1;
        check("reset_in_ready",  {127'd0, in_ready},  128'd1);
        check("reset_out_valid", {127'd0, out_valid}, 128'd0);
        check("reset_busy",      {127'd0, busy},      128'd0);
        check("reset_result",    result,              128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        fork
            forever begin
                @(posedge clk);
                #1;
                check("cyc_in_ready",  {127'd0, in_ready},  {127'd0, (m_cnt == 0) && !m_ov});
                check("cyc_busy",      {127'd0, busy},      {127'd0, m_cnt != 0});
                check("cyc_out_valid", {127'd0, out_valid}, {127'd0, m_ov});
                if (m_ov) check("cyc_result", result, m_res);
            end
        join_none

        do_op("u16_ffff", 2'd0, 1'b0, 64'hFFFF, 64'hFFFF, 128'hFFFE0001, 3);
        do_op("s16_m1x2", 2'd0, 1'b1, 64'h1234_0000_0000_FFFF, 64'h2,
              128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 3);
        do_op("s64_min2", 2'd3, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              128'h4000_0000_0000_0000_0000_0000_0000_0000, 18);
        do_op("u32", 2'd1, 1'b0, 64'hDEAD_0000_FFFF_FFFF, 64'h2, 128'h1_FFFF_FFFE, 6);
        do_op("s48_m3x5", 2'd2, 1'b1, 64'h0000_FFFF_FFFF_FFFD, 64'h5,
              128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1, 11);
        do_op("s16_zero", 2'd0, 1'b1, 64'h0, 64'h8000, 128'h0, 3);
        do_op("u64_max", 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 18);
        do_op("s32_mixed", 2'd1, 1'b1, 64'h8000_0000, 64'h7FFF_FFFF,
              128'hFFFF_FFFF_FFFF_FFFF_C000_0000_8000_0000, 6);

        // Back-pressure: result held, no acceptance during handoff.
        @(negedge clk);
        prec = 2'd0; signed_op = 1'b0; a = 64'd3; b = 64'd5; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(cnt);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("hold_result",   result,              128'd15);
            check("hold_in_ready", {127'd0, in_ready},  128'd0);
        end
        @(negedge clk);
        a = 64'd7; b = 64'd9; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("handoff_no_accept_busy", {127'd0, busy},      128'd0);
        check("handoff_out_valid",      {127'd0, out_valid}, 128'd0);
        check("handoff_in_ready",       {127'd0, in_ready},  128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("next_accept_busy", {127'd0, busy}, 128'd1);
        wait_valid(cnt);
        check("next_result", result, 128'd63);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of a 64-bit multiply.
        @(negedge clk);
        prec = 2'd3; signed_op = 1'b0; a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("pre_reset_busy", {127'd0, busy}, 128'd1);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_busy",      {127'd0, busy},      128'd0);
        check("rst_result",    result,              128'd0);
        check("rst_in_ready",  {127'd0, in_ready},  128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_reset_3x4", 2'd0, 1'b0, 64'd3, 64'd4, 128'd12, 3);

        repeat (3) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
